// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, controller states and NZCV bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed-overflow outputs.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c,
    output logic             o_v
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_full;

    // Subtraction is a + ~b + 1, so C=1 means no borrow.
    assign w_bx   = i_sub ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum  = w_full[WIDTH-1:0];
    assign o_c    = w_full[WIDTH];
    assign o_v    = (i_a[WIDTH-1] == w_bx[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle logic/arith, iterative shifts, shift-add multiply,
// valid/ready handshakes and an architectural NZCV register committed on result handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = SHW + 1;

    state_t             r_state;
    alu_op_t            r_op;
    logic               r_setf;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic               r_v;
    logic [3:0]         r_flags;

    alu_op_t            w_op;
    logic [WIDTH-1:0]   w_bo;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH-1:0]   w_sum;
    logic               w_c;
    logic               w_v;
    logic [WIDTH:0]     w_sh_a;
    logic [WIDTH:0]     w_sh_y;

    // One-bit shift step; the top bit of the result is the bit shifted out.
    function automatic logic [WIDTH:0] shift1(input alu_op_t f_op, input logic [WIDTH-1:0] f_v);
        case (f_op)
            OP_SLL:  return {f_v, 1'b0};
            OP_SRA:  return {f_v[0], f_v[WIDTH-1], f_v[WIDTH-1:1]};
            default: return {f_v[0], 1'b0, f_v[WIDTH-1:1]};
        endcase
    endfunction

    assign w_op   = alu_op_t'(op);
    assign w_bo   = alu_src ? imm : b;
    assign w_amt  = w_bo[SHW-1:0];
    assign w_sh_a = shift1(w_op, a);
    assign w_sh_y = shift1(r_op, r_y);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a   (a),
        .i_b   (w_bo),
        .i_sub (w_op == OP_SUB),
        .o_sum (w_sum),
        .o_c   (w_c),
        .o_v   (w_v)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign flags     = r_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= OP_ADD;
            r_setf   <= 1'b0;
            r_y      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_flags  <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op   <= w_op;
                        r_setf <= set_flags;
                        r_c    <= 1'b0;
                        r_v    <= 1'b0;
                        case (w_op)
                            OP_ADD, OP_SUB: begin
                                r_y     <= w_sum;
                                r_c     <= w_c;
                                r_v     <= w_v;
                                r_state <= DONE;
                            end
                            OP_AND: begin
                                r_y     <= a & w_bo;
                                r_state <= DONE;
                            end
                            OP_OR: begin
                                r_y     <= a | w_bo;
                                r_state <= DONE;
                            end
                            OP_MUL: begin
                                r_y      <= '0;
                                r_mcand  <= a;
                                r_mplier <= w_bo;
                                r_cnt    <= CNT_W'(WIDTH);
                                r_state  <= BUSY;
                            end
                            default: begin
                                // The first shift step happens on accept so a shift by k takes k cycles.
                                r_cnt <= {1'b0, w_amt};
                                if (w_amt == '0) begin
                                    r_y     <= a;
                                    r_state <= DONE;
                                end else begin
                                    r_y     <= w_sh_a[WIDTH-1:0];
                                    r_c     <= w_sh_a[WIDTH];
                                    r_state <= (w_amt == SHW'(1)) ? DONE : BUSY;
                                end
                            end
                        endcase
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_op == OP_MUL) begin
                        if (r_mplier[0]) begin
                            r_y <= r_y + r_mcand;
                        end
                        r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_y <= w_sh_y[WIDTH-1:0];
                        r_c <= w_sh_y[WIDTH];
                        if (r_cnt == CNT_W'(2)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                        if (r_setf) begin
                            r_flags[FLAG_N] <= r_y[WIDTH-1];
                            r_flags[FLAG_Z] <= (r_y == '0);
                            r_flags[FLAG_C] <= r_c;
                            r_flags[FLAG_V] <= r_v;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc with hand-computed results, latencies and flags.
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        alu_src;
    logic        set_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .imm       (imm),
        .alu_src   (alu_src),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid; lat counts edges from the accept edge.
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic [31:0] t_imm, input logic t_src, input logic t_sf,
                          output int t_lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        op = t_op; a = t_a; b = t_b; imm = t_imm; alu_src = t_src; set_flags = t_sf;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t_lat = 1;
        while (!out_valid && t_lat < 100) begin
            @(posedge clk); #1;
            t_lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = '0; b = '0; imm = '0;
        alu_src = 1'b0; set_flags = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_y", y, 0);

        // ADD signed overflow
        run_op(3'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, lat);
        chk("add_lat", lat, 1);
        chk("add_y", y, 32'h8000_0000);
        chk("add_flags_pre", flags, 4'b0000);
        handshake();
        chk("add_flags", flags, 4'b1001);
        chk("add_in_ready", in_ready, 1);
        chk("add_out_valid", out_valid, 0);

        // SUB using immediate; b deliberately different
        run_op(3'd1, 32'd5, 32'd99, 32'd5, 1'b1, 1'b1, lat);
        chk("sub_lat", lat, 1);
        chk("sub_y", y, 32'h0);
        handshake();
        chk("sub_flags", flags, 4'b0110);

        // SUB with borrow, flags not committed
        run_op(3'd1, 32'd3, 32'd0, 32'd5, 1'b1, 1'b0, lat);
        chk("sub_nf_y", y, 32'hFFFF_FFFE);
        handshake();
        chk("sub_nf_flags", flags, 4'b0110);

        // SRA by 4
        run_op(3'd6, 32'h8000_0010, 32'd4, 32'h0, 1'b0, 1'b1, lat);
        chk("sra_lat", lat, 4);
        chk("sra_y", y, 32'hF800_0001);
        handshake();
        chk("sra_flags", flags, 4'b1000);

        // SLL by 1, carry out set
        run_op(3'd4, 32'h8000_0001, 32'd1, 32'h0, 1'b0, 1'b1, lat);
        chk("sll1_lat", lat, 1);
        chk("sll1_y", y, 32'h0000_0002);
        handshake();
        chk("sll1_flags", flags, 4'b0010);

        // SRL by 0x24: only low 5 bits count, amount 4
        run_op(3'd5, 32'h8000_0018, 32'h0, 32'h24, 1'b1, 1'b1, lat);
        chk("srl_lat", lat, 4);
        chk("srl_y", y, 32'h0800_0001);
        handshake();
        chk("srl_flags", flags, 4'b0010);

        // SLL by 0
        run_op(3'd4, 32'h8000_0001, 32'd0, 32'h0, 1'b0, 1'b1, lat);
        chk("sll0_lat", lat, 1);
        chk("sll0_y", y, 32'h8000_0001);
        handshake();
        chk("sll0_flags", flags, 4'b1000);

        // AND
        run_op(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 1'b0, 1'b0, lat);
        chk("and_y", y, 32'h0000_F000);
        handshake();

        // MUL
        run_op(3'd7, 32'h0001_0003, 32'h0000_0005, 32'h0, 1'b0, 1'b0, lat);
        chk("mul_lat", lat, 33);
        chk("mul_y", y, 32'h0005_000F);
        handshake();
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, lat);
        chk("mul2_y", y, 32'h1);
        handshake();
        chk("mul2_flags", flags, 4'b0000);

        // Back-pressure: DONE holds while in_valid pulses arrive
        run_op(3'd0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1, lat);
        chk("bp_y0", y, 32'd3);
        for (int i = 0; i < 10; i++) begin
            op = 3'd3; a = 32'hFFFF_0000; b = 32'h1234; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_y", y, 32'd3);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_flags", flags, 4'b0000);
        end
        in_valid = 1'b0;
        handshake();
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_flags", flags, 4'b0000);
        @(posedge clk); #1;
        chk("bp_idle_out_valid", out_valid, 0);
        chk("bp_idle_y", y, 32'd3);

        // Set flags nonzero, then reset mid-MUL
        run_op(3'd0, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, lat);
        handshake();
        chk("pre_rst_flags", flags, 4'b1001);
        op = 3'd7; a = 32'h1234_5678; b = 32'h9; alu_src = 1'b0; set_flags = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_mul_busy", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_flags", flags, 4'b0000);
        chk("mr_y", y, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(3'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0, 1'b0, 1'b0, lat);
        chk("or_lat", lat, 1);
        chk("or_y", y, 32'h0000_00FF);
        handshake();
        chk("or_flags", flags, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised integer ALU: the successor to the single-cycle combinational ALU in the Lab2 datapath. It keeps that ALU's add/subtract/AND/OR behaviour and its B/immediate operand select. It adds iterative shifts and a shift-add multiplier behind a valid/ready handshake, plus an architectural NZCV flag register. It sits between the register-file read stage and write-back, and the controller stalls on `in_ready`.

## Interface
- `WIDTH`, 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; not overridden).

Ports:
- `clk`  in  1: sole clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operation request.
- `in_ready`  out  1: block can accept a request.
- `op`  in  3: `alu_op_t` opcode.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: register operand B.
- `imm`  in  WIDTH: immediate operand.
- `alu_src`  in  1: 1 selects `imm` as operand B, 0 selects `b`.
- `set_flags`  in  1: commit NZCV on completion of this operation.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts result.
- `y`  out  WIDTH: result.
- `flags`  out  4: architectural {N,Z,C,V} register.

## Operation
- Operand B (`bo`) = `alu_src ? imm : b`, captured with `a`, `op` and `set_flags` on accept (`in_valid && in_ready`).
- Opcodes: ADD=0 (a+bo), SUB=1 (a+~bo+1), AND=2, OR=3, SLL=4, SRL=5, SRA=6, MUL=7 (low WIDTH bits of a*bo, unsigned).
- Shift amount = bo[SHW-1:0]; upper bits of bo ignored.
- FSM states:
  - IDLE: `in_ready`=1. On accept, ADD/SUB/AND/OR compute the result into the result register and go to DONE. SLL/SRL/SRA go to BUSY with the counter loaded with the shift amount; if the amount is 0, they go straight to DONE with y=a. MUL goes to BUSY with the counter = WIDTH.
  - BUSY: shifts move one bit per cycle and the counter decrements; at counter 1, the final step is taken and the FSM goes to DONE. MUL performs one shift-add step per cycle (multiplicand shifts left, multiplier shifts right, add if multiplier LSB = 1); after WIDTH steps it goes to DONE.
  - DONE: `out_valid`=1 and `y` is stable. On `out_ready`, the FSM goes to IDLE and, if the captured `set_flags`=1, `flags` loads the pending NZCV.
- Pending flags:
  - N = y[WIDTH-1]; Z = (y==0).
  - ADD/SUB: C = carry out of bit WIDTH-1 (SUB: C=1 means no borrow); V = signed overflow.
  - AND/OR/MUL: C=0, V=0.
  - Shifts: C = last bit shifted out (0 if amount 0); V=0.
- SRA replicates a[WIDTH-1]. SLL/SRL shift in 0.
- `in_valid` is ignored outside IDLE; requests are not queued.

## Timing
- Reset: state=IDLE, `in_ready`=1, `out_valid`=0, `y`=0, `flags`=4'b0000, counter=0. Reset mid-BUSY or mid-DONE aborts the operation; no flag commit occurs.
- Latency from the accept edge to `out_valid`:
  - ADD/SUB/AND/OR: 1 cycle.
  - Shift by k: max(k,1) cycles.
  - MUL: WIDTH+1 cycles.
- Back-pressure: DONE holds indefinitely while `out_ready`=0; `y` and `out_valid` do not change.
- Result handshake and new accept never share a cycle; peak throughput is one op per 2 cycles. `in_ready` rises in the cycle after the output handshake.
- `flags` changes only on the clock edge of the output handshake, so a following operation observes the committed flags.

## Structure
- Package `alu_pkg`: `alu_op_t` enum (8 codes above), `state_t` {IDLE, BUSY, DONE}, flag bit index constants (N=3, Z=2, C=1, V=0).
- Sub-module `alu_addsub` (combinational WIDTH-bit add/sub with C and V outputs), instantiated once. Shifter and multiplier datapaths stay inline in `alu_mc`.

## Test plan
- After reset: `in_ready`=1, `out_valid`=0, `flags`=0. ADD a=0x7FFFFFFF, b=1, set_flags=1 → y=0x80000000 after 1 cycle; after handshake, flags=N1 Z0 C0 V1.
- SUB a=5, imm=5, alu_src=1 → y=0, flags=N0 Z1 C1 V0. Repeat with set_flags=0 → flags unchanged.
- SRA a=0x80000010, bo=4 → `out_valid` 4 cycles after accept; y=0xF8000001, C=0. SLL a=0x80000001, bo=0 → y=a after 1 cycle, C=0.
- MUL a=0x0001_0003, b=0x0000_0005 → y=0x0005_000F exactly 33 cycles after accept. MUL 0xFFFFFFFF×0xFFFFFFFF → y=1.
- Hold `out_ready`=0 for 10 cycles in DONE: y stable, `in_ready`=0, `in_valid` pulses ignored. Then `out_ready`=1 → IDLE next cycle.
- Assert `rst` mid-MUL (cycle 12) → immediately `out_valid`=0, `in_ready`=1, `flags`=0. A subsequent OR a=0xF0, b=0x0F → y=0xFF.
